// File: rtl/pipe_muladd.sv
// -----------------------------------------------------------------------------
// pipe_muladd
//
// Pipelined unsigned multiply-add: Product = Quotient * Divisor + Mod.
// It is built as a shift-and-add multiplier with one registered stage per
// Divisor bit. Stage 0 adds the addend and the bit-0 partial product. Each
// later stage k adds (Quotient << k) when Divisor bit k is set. The operands
// travel down the pipe next to their running sum.
//
// The block is the exact inverse of a restoring divider. Feeding it the
// divider's (quotient, divisor, remainder) triple rebuilds the dividend.
//
// Parameters
//   A_LEN     width of the Quotient operand
//   B_LEN     width of the Divisor and Mod operands, and the pipeline depth
//
// Ports
//   CLK       clock, rising edge
//   RSTN      asynchronous active-low reset; clears every stage
//   EN        input valid; operands are sampled on each rising edge with EN=1
//   Quotient  [A_LEN-1:0] unsigned multiplicand
//   Divisor   [B_LEN-1:0] unsigned multiplier
//   Mod       [B_LEN-1:0] unsigned addend
//   Product   [A_LEN+B_LEN-1:0] result; zero whenever RDY is low
//   RDY       Product is valid this cycle, B_LEN cycles after the sample
// -----------------------------------------------------------------------------
module pipe_muladd #(
  parameter int A_LEN = 8,
  parameter int B_LEN = 4
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     EN,
  input  logic [A_LEN-1:0]         Quotient,
  input  logic [B_LEN-1:0]         Divisor,
  input  logic [B_LEN-1:0]         Mod,
  output logic [A_LEN+B_LEN-1:0]   Product,
  output logic                     RDY
);

  localparam int W = A_LEN + B_LEN;

  // Per-stage state. Index k holds the registers of stage Sk.
  logic [B_LEN-1:0][W-1:0]     acc_r;
  logic [B_LEN-1:0][A_LEN-1:0] quot_r;
  logic [B_LEN-1:0][B_LEN-1:0] div_r;
  logic [B_LEN-1:0]            vld_r;

  // All stages share a single register block. Any stage whose incoming valid
  // is low loads zeros, so bubbles leave the pipe as all-zero words. That
  // keeps Product at zero whenever RDY is low, with no output mux.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_r  <= '0;
      quot_r <= '0;
      div_r  <= '0;
      vld_r  <= '0;
    end else begin
      if (EN) begin
        acc_r[0]  <= W'(Mod) + (Divisor[0] ? W'(Quotient) : W'(0));
        quot_r[0] <= Quotient;
        div_r[0]  <= Divisor;
        vld_r[0]  <= 1'b1;
      end else begin
        acc_r[0]  <= '0;
        quot_r[0] <= '0;
        div_r[0]  <= '0;
        vld_r[0]  <= 1'b0;
      end

      for (int k = 1; k < B_LEN; k++) begin
        if (vld_r[k-1]) begin
          acc_r[k]  <= acc_r[k-1]
                       + (div_r[k-1][k] ? (W'(quot_r[k-1]) << k) : W'(0));
          quot_r[k] <= quot_r[k-1];
          div_r[k]  <= div_r[k-1];
          vld_r[k]  <= 1'b1;
        end else begin
          acc_r[k]  <= '0;
          quot_r[k] <= '0;
          div_r[k]  <= '0;
          vld_r[k]  <= 1'b0;
        end
      end
    end
  end

  // The last stage's forwarded operands have no consumer.
  // Each stage reads only one Divisor bit.
  logic unused_fwd;
  assign unused_fwd = ^{quot_r[B_LEN-1], div_r};

  assign Product = acc_r[B_LEN-1];
  assign RDY     = vld_r[B_LEN-1];

endmodule

// File: tb/tb_pipe_muladd.sv
// -----------------------------------------------------------------------------
// tb_pipe_muladd
//
// Self-checking bench for pipe_muladd with A_LEN=8 and B_LEN=4.
//
// The stimulus side pushes each expected result onto a scoreboard queue,
// together with the cycle on which it is due. A monitor on the falling edge
// pops and compares every RDY beat. On idle cycles it checks that Product is
// zero, and it flags any result that arrives late or was never produced.
// -----------------------------------------------------------------------------
module tb_pipe_muladd;

  localparam int A_LEN = 8;
  localparam int B_LEN = 4;
  localparam int W     = A_LEN + B_LEN;

  logic             CLK;
  logic             RSTN;
  logic             EN;
  logic [A_LEN-1:0] Quotient;
  logic [B_LEN-1:0] Divisor;
  logic [B_LEN-1:0] Mod;
  logic [W-1:0]     Product;
  logic             RDY;

  pipe_muladd #(.A_LEN(A_LEN), .B_LEN(B_LEN)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .EN       (EN),
    .Quotient (Quotient),
    .Divisor  (Divisor),
    .Mod      (Mod),
    .Product  (Product),
    .RDY      (RDY)
  );

  typedef struct {
    logic [A_LEN-1:0] q;
    logic [B_LEN-1:0] d;
    logic [B_LEN-1:0] m;
    logic [W-1:0]     exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] exp;
    int           due;
    string        name;
  } sb_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Free-running clock with a 10-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count rising edges; scoreboard due times are expressed in this count.
  always @(posedge CLK) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Drive one cycle of inputs at the falling edge. A valid op is due
  // B_LEN rising edges later.
  task automatic applyStimulus(input logic en, input logic [A_LEN-1:0] q,
                               input logic [B_LEN-1:0] d, input logic [B_LEN-1:0] m,
                               input logic [W-1:0] exp, input string name);
    @(negedge CLK);
    EN       = en;
    Quotient = q;
    Divisor  = d;
    Mod      = m;
    if (en) sb_q.push_back('{exp, cycle + B_LEN, name});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, "");
  endtask

  // Output monitor. Every RDY beat must match the head of the scoreboard on
  // its due cycle. Every idle cycle must show Product == 0.
  always @(negedge CLK) begin
    if (RDY === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("spurious_rdy", {31'b0, RDY}, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        checkOutput({"product_", e.name}, {20'b0, Product}, {20'b0, e.exp});
        checkOutput({"latency_", e.name}, cycle, e.due);
      end
    end else begin
      checkOutput("idle_product", {20'b0, Product}, 32'd0);
      if (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
        checkOutput({"rdy_", sb_q[0].name}, {31'b0, RDY}, 32'd1);
        void'(sb_q.pop_front());
      end
    end
  end

  // Hard stop in case anything hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  vec_t vecs[10];

  initial begin
    int dvd, dv;
    logic [A_LEN-1:0] rq;
    logic [B_LEN-1:0] rd, rm;

    vecs[0] = '{8'h2A, 4'h5, 4'h3, 12'h0D5};
    vecs[1] = '{8'hFF, 4'hF, 4'hF, 12'hF00};
    vecs[2] = '{8'hC8, 4'h0, 4'h7, 12'h007};
    vecs[3] = '{8'h01, 4'h1, 4'h0, 12'h001};
    vecs[4] = '{8'h80, 4'h8, 4'h1, 12'h401};
    vecs[5] = '{8'h10, 4'h3, 4'h2, 12'h032};
    vecs[6] = '{8'h00, 4'hF, 4'hF, 12'h00F};
    vecs[7] = '{8'hFF, 4'h1, 4'h0, 12'h0FF};
    vecs[8] = '{8'h7F, 4'h2, 4'h1, 12'h0FF};
    vecs[9] = '{8'h55, 4'hA, 4'h5, 12'h357};

    EN = 1'b0; Quotient = '0; Divisor = '0; Mod = '0;
    RSTN = 1'b0;

    // Outputs must clear under reset, before any clock edge arrives.
    #3;
    checkOutput("reset_product", {20'b0, Product}, 32'd0);
    checkOutput("reset_rdy", {31'b0, RDY}, 32'd0);
    #20;
    checkOutput("reset_hold_rdy", {31'b0, RDY}, 32'd0);
    RSTN = 1'b1;

    // Single op alone: exactly one RDY beat, with zeros around it.
    applyStimulus(1'b1, vecs[0].q, vecs[0].d, vecs[0].m, vecs[0].exp, "single");
    idle(8);

    // Table vectors back-to-back, including the extremes.
    for (int i = 1; i < 10; i++)
      applyStimulus(1'b1, vecs[i].q, vecs[i].d, vecs[i].m, vecs[i].exp, $sformatf("vec%0d", i));
    idle(6);

    // Stream of 20 random operands.
    for (int i = 0; i < 20; i++) begin
      rq = A_LEN'($urandom_range(0, 255));
      rd = B_LEN'($urandom_range(0, 15));
      rm = B_LEN'($urandom_range(0, 15));
      applyStimulus(1'b1, rq, rd, rm, W'(rq) * W'(rd) + W'(rm), $sformatf("stream%0d", i));
    end
    idle(6);

    // Bubble pattern 1,0,1,1,0,1.
    applyStimulus(1'b1, 8'h12, 4'h3, 4'h1, 12'h037, "bub0");
    applyStimulus(1'b0, 8'hEE, 4'hF, 4'hF, 12'h000, "");
    applyStimulus(1'b1, 8'h33, 4'h4, 4'h2, 12'h0CE, "bub2");
    applyStimulus(1'b1, 8'hF0, 4'h9, 4'h8, 12'h878, "bub3");
    applyStimulus(1'b0, 8'hAA, 4'hA, 4'hA, 12'h000, "");
    applyStimulus(1'b1, 8'h01, 4'hF, 4'hE, 12'h01D, "bub5");
    idle(6);

    // Async clear while a result sits on the output. Reset falls mid-cycle
    // and the outputs must drop without waiting for an edge.
    applyStimulus(1'b1, 8'hFF, 4'hF, 4'hF, 12'hF00, "async_out");
    idle(4);
    #2;
    RSTN = 1'b0;
    #1;
    checkOutput("async_rdy", {31'b0, RDY}, 32'd0);
    checkOutput("async_product", {20'b0, Product}, 32'd0);
    #1;
    RSTN = 1'b1;
    idle(4);

    // Three ops in flight, then a reset pulse between edges. None of the
    // three results may ever appear.
    applyStimulus(1'b1, 8'h11, 4'h2, 4'h1, 12'h023, "lost0");
    applyStimulus(1'b1, 8'h22, 4'h3, 4'h2, 12'h068, "lost1");
    applyStimulus(1'b1, 8'h33, 4'h4, 4'h3, 12'h0CF, "lost2");
    @(posedge CLK);
    #2;
    EN   = 1'b0;
    RSTN = 1'b0;
    #1;
    checkOutput("midop_rdy", {31'b0, RDY}, 32'd0);
    checkOutput("midop_product", {20'b0, Product}, 32'd0);
    sb_q.delete();
    #4;
    RSTN = 1'b1;
    applyStimulus(1'b1, 8'h2A, 4'h5, 4'h3, 12'h0D5, "after_reset");
    idle(8);

    // Round trip through divider outputs: (dvd / dv, dv, dvd % dv).
    for (int i = 0; i < 16; i++) begin
      dvd = $urandom_range(0, 255);
      dv  = $urandom_range(1, 15);
      applyStimulus(1'b1, A_LEN'(dvd / dv), B_LEN'(dv), B_LEN'(dvd % dv),
                    W'(dvd), $sformatf("roundtrip%0d", i));
    end

    // Drain the pipe, with a bounded wait.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) idle(1);
    idle(2);
    checkOutput("drain_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
